knn_infer_system: RTL and testbench

//  k-nearest-neighbour classifier. Streams 2^L labelled training matrices (MxN, W-bit unsigned

---
 rtl/knn_pkg.sv | 37 +++
 rtl/knn_burst_distance.sv | 47 ++++
 rtl/knn_infer_system.sv | 199 +++++++++++++++++++
 tb/tb_knn_infer_system.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : knn_pkg
//  Description : Shared parameters, derived widths and FSM state type for the
//                k-nearest-neighbour inference block.
//  Revision    : 1.0  initial release
// ============================================================================
package knn_pkg;

    // Base parameters
    localparam int M            = 5;    // matrix rows
    localparam int N            = 10;   // matrix columns
    localparam int W            = 32;   // element width (unsigned)
    localparam int MAX_ELEMENTS = 16;   // lanes per bus burst
    localparam int TYPE_W       = 3;    // class-label width
    localparam int K            = 7;    // neighbours voted
    localparam int L            = 6;    // log2 of training-set size

    // Derived values
    localparam int MN      = M * N;
    localparam int B       = (MN + MAX_ELEMENTS - 1) / MAX_ELEMENTS;   // bursts per sample
    localparam int DIST_W  = W + $clog2(MN);                           // distance width
    localparam int NS      = 1 << L;                                   // number of samples
    localparam int NT      = 1 << TYPE_W;                              // number of labels
    localparam int BURST_W = (B > 1) ? $clog2(B) : 1;
    localparam int PASS_W  = (K > 1) ? $clog2(K) : 1;
    localparam int CNT_W   = $clog2(K + 1);                            // vote counter width

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,   // idle / accepting bursts
        ST_SELECT = 2'd1,   // K min-scans over the distance table
        ST_VOTE   = 2'd2,   // argmax over label counters
        ST_RESULT = 2'd3    // result held until the next set starts
    } state_t;

endpackage
`default_nettype wire

// File: rtl/knn_burst_distance.sv
`default_nettype none
// ============================================================================
//  Module      : knn_burst_distance
//  Description : Combinational L1 distance of one burst. Each lane forms
//                |train - query|; lanes whose element index lies beyond the
//                end of the matrix contribute 0. Lane results are summed.
//  Ports       : i_train  - training burst, lane j = bits [W*(j+1)-1 -: W]
//                i_query  - query burst, same layout
//                i_burst  - index of this burst within the sample
//                o_dist   - sum of valid lane differences
//  Revision    : 1.0  initial release
// ============================================================================
module knn_burst_distance
    import knn_pkg::*;
(
    input  logic [W*MAX_ELEMENTS-1:0] i_train,
    input  logic [W*MAX_ELEMENTS-1:0] i_query,
    input  logic [BURST_W-1:0]        i_burst,
    output logic [DIST_W-1:0]         o_dist
);

    logic [W-1:0]            w_diff [MAX_ELEMENTS];
    logic [MAX_ELEMENTS-1:0] w_valid;

    genvar j;
    generate
        for (j = 0; j < MAX_ELEMENTS; j++) begin : g_lane
            logic [W-1:0] w_a;
            logic [W-1:0] w_b;
            assign w_a        = i_train[W*(j+1)-1 -: W];
            assign w_b        = i_query[W*(j+1)-1 -: W];
            // Element index of this lane within the row-major matrix
            assign w_valid[j] = (int'(i_burst) * MAX_ELEMENTS + j) < MN;
            assign w_diff[j]  = !w_valid[j] ? '0 :
                                (w_a > w_b) ? (w_a - w_b) : (w_b - w_a);
        end
    endgenerate

    always_comb begin
        o_dist = '0;
        for (int k = 0; k < MAX_ELEMENTS; k++) begin
            o_dist = o_dist + DIST_W'(w_diff[k]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/knn_infer_system.sv
`default_nettype none
// ============================================================================
//  Module      : knn_infer_system
//  Description : k-nearest-neighbour classifier. Accumulates the L1 distance
//                of each streamed training sample against the re-sent query,
//                stores {distance,type} per sample, selects the K closest
//                (ties -> lowest index) and majority-votes their labels
//                (ties -> smallest label).
//  Ports       : clk, rst (async, active high)
//                read_done / training_data / training_data_type / input_data
//                    - burst input handshake
//                data_request - pulse: next burst of same sample may be sent
//                done         - pulse: sample distance stored
//                done_calc    - pulse: all samples stored
//                inferred_type / inference_done - voted class, held valid
//  Revision    : 1.0  initial release
// ============================================================================
module knn_infer_system
    import knn_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read_done,
    input  logic [W*MAX_ELEMENTS-1:0] training_data,
    input  logic [TYPE_W-1:0]         training_data_type,
    input  logic [W*MAX_ELEMENTS-1:0] input_data,
    output logic                      data_request,
    output logic                      done,
    output logic                      done_calc,
    output logic [TYPE_W-1:0]         inferred_type,
    output logic                      inference_done
);

    state_t              r_state;
    state_t              w_state_next;

    logic [BURST_W-1:0]  r_burst;
    logic [L-1:0]        r_sample;
    logic [DIST_W-1:0]   r_acc;
    logic [DIST_W-1:0]   w_burst_dist;
    logic [DIST_W-1:0]   w_acc_next;
    logic [DIST_W-1:0]   r_dist [NS];
    logic [TYPE_W-1:0]   r_type [NS];
    logic [NS-1:0]       r_used;
    logic [CNT_W-1:0]    r_votes [NT];

    // Selection scan
    logic [PASS_W-1:0]   r_pass;
    logic [L-1:0]        r_idx;
    logic [L-1:0]        r_best_idx;
    logic [DIST_W-1:0]   r_best_dist;
    logic                r_found;

    // Vote scan
    logic [TYPE_W-1:0]   r_vidx;
    logic [TYPE_W-1:0]   r_vbest_lbl;
    logic [CNT_W-1:0]    r_vbest_cnt;

    logic w_accept, w_last_burst, w_last_sample;
    logic w_cand_better, w_scan_end, w_last_pass;
    logic [L-1:0] w_pick_idx;
    logic w_vote_better, w_vote_end;
    logic [TYPE_W-1:0] w_vote_lbl;

    knn_burst_distance u_dist (
        .i_train (training_data),
        .i_query (input_data),
        .i_burst (r_burst),
        .o_dist  (w_burst_dist)
    );

    // A new set may start from RESULT, so both states accept bursts
    assign w_accept      = read_done && (r_state == ST_LOAD || r_state == ST_RESULT);
    assign w_last_burst  = (r_burst == BURST_W'(B - 1));
    assign w_last_sample = (r_sample == {L{1'b1}});
    assign w_acc_next    = r_acc + w_burst_dist;

    // Strict less-than keeps the earliest index among equal distances
    assign w_cand_better = !r_used[r_idx] && (!r_found || (r_dist[r_idx] < r_best_dist));
    assign w_pick_idx    = w_cand_better ? r_idx : r_best_idx;
    assign w_scan_end    = (r_idx == {L{1'b1}});
    assign w_last_pass   = (r_pass == PASS_W'(K - 1));

    // Strict greater-than keeps the smallest label among equal counts
    assign w_vote_better = (r_votes[r_vidx] > r_vbest_cnt);
    assign w_vote_lbl    = w_vote_better ? r_vidx : r_vbest_lbl;
    assign w_vote_end    = (r_vidx == {TYPE_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_LOAD;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD, ST_RESULT: begin
                if (w_accept)
                    w_state_next = (w_last_burst && w_last_sample) ? ST_SELECT : ST_LOAD;
            end
            ST_SELECT: if (w_scan_end && w_last_pass) w_state_next = ST_VOTE;
            ST_VOTE:   if (w_vote_end)                w_state_next = ST_RESULT;
            default:   w_state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_request   <= 1'b0;
            done           <= 1'b0;
            done_calc      <= 1'b0;
            inferred_type  <= '0;
            inference_done <= 1'b0;
            r_burst        <= '0;
            r_sample       <= '0;
            r_acc          <= '0;
            r_used         <= '0;
            r_pass         <= '0;
            r_idx          <= '0;
            r_best_idx     <= '0;
            r_best_dist    <= '0;
            r_found        <= 1'b0;
            r_vidx         <= '0;
            r_vbest_lbl    <= '0;
            r_vbest_cnt    <= '0;
            for (int i = 0; i < NS; i++) begin
                r_dist[i] <= '0;
                r_type[i] <= '0;
            end
            for (int i = 0; i < NT; i++) r_votes[i] <= '0;
        end else begin
            data_request <= 1'b0;
            done         <= 1'b0;
            done_calc    <= 1'b0;

            if (w_accept) begin
                if (r_state == ST_RESULT) begin
                    inference_done <= 1'b0;
                    inferred_type  <= '0;
                end
                if (!w_last_burst) begin
                    r_acc        <= w_acc_next;
                    r_burst      <= r_burst + BURST_W'(1);
                    data_request <= 1'b1;
                end else begin
                    r_dist[r_sample] <= w_acc_next;
                    r_type[r_sample] <= training_data_type;
                    r_acc            <= '0;
                    r_burst          <= '0;
                    done             <= 1'b1;
                    r_sample         <= r_sample + L'(1);
                    if (w_last_sample) begin
                        // Table complete: arm the selection scan with clean state
                        done_calc <= 1'b1;
                        r_used    <= '0;
                        r_pass    <= '0;
                        r_idx     <= '0;
                        r_found   <= 1'b0;
                        for (int i = 0; i < NT; i++) r_votes[i] <= '0;
                    end
                end
            end

            if (r_state == ST_SELECT) begin
                if (w_cand_better) begin
                    r_best_idx  <= r_idx;
                    r_best_dist <= r_dist[r_idx];
                    r_found     <= 1'b1;
                end
                r_idx <= r_idx + L'(1);
                if (w_scan_end) begin
                    r_used[w_pick_idx]          <= 1'b1;
                    r_votes[r_type[w_pick_idx]] <= r_votes[r_type[w_pick_idx]] + CNT_W'(1);
                    r_found                     <= 1'b0;
                    r_pass                      <= r_pass + PASS_W'(1);
                    if (w_last_pass) begin
                        r_vidx      <= '0;
                        r_vbest_lbl <= '0;
                        r_vbest_cnt <= '0;
                    end
                end
            end

            if (r_state == ST_VOTE) begin
                if (w_vote_better) begin
                    r_vbest_lbl <= r_vidx;
                    r_vbest_cnt <= r_votes[r_vidx];
                end
                r_vidx <= r_vidx + TYPE_W'(1);
                if (w_vote_end) begin
                    inferred_type  <= w_vote_lbl;
                    inference_done <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_knn_infer_system.sv
`default_nettype none
// ============================================================================
//  Module      : tb_knn_infer_system
//  Description : Self-checking bench for knn_infer_system. Scenario table of
//                {scenario, query value, expected label}; expected label -1
//                means "take it from the reference model".
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_knn_infer_system;
    import knn_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      read_done = 1'b0;
    logic [W*MAX_ELEMENTS-1:0] training_data = '0;
    logic [TYPE_W-1:0]         training_data_type = '0;
    logic [W*MAX_ELEMENTS-1:0] input_data = '0;
    logic                      data_request;
    logic                      done;
    logic                      done_calc;
    logic [TYPE_W-1:0]         inferred_type;
    logic                      inference_done;

    knn_infer_system dut (
        .clk                (clk),
        .rst                (rst),
        .read_done          (read_done),
        .training_data      (training_data),
        .training_data_type (training_data_type),
        .input_data         (input_data),
        .data_request       (data_request),
        .done               (done),
        .done_calc          (done_calc),
        .inferred_type      (inferred_type),
        .inference_done     (inference_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    longint unsigned tr [NS][MN];
    longint unsigned qv [MN];
    int              ty [NS];

    typedef struct {
        int          scen;
        int unsigned q;
        int          exp;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: rank every sample by (distance, index); the K best vote.
    function automatic int model_type();
        longint unsigned d [NS];
        int votes [NT];
        int best;
        for (int s = 0; s < NS; s++) begin
            d[s] = 0;
            for (int e = 0; e < MN; e++)
                d[s] += (tr[s][e] > qv[e]) ? tr[s][e] - qv[e] : qv[e] - tr[s][e];
        end
        for (int l = 0; l < NT; l++) votes[l] = 0;
        for (int s = 0; s < NS; s++) begin
            int rank = 0;
            for (int t = 0; t < NS; t++)
                if (d[t] < d[s] || (d[t] == d[s] && t < s)) rank++;
            if (rank < K) votes[ty[s]]++;
        end
        best = 0;
        for (int l = 1; l < NT; l++) if (votes[l] > votes[best]) best = l;
        return best;
    endfunction

    task automatic prep(input int scen, input int unsigned q);
        for (int e = 0; e < MN; e++) qv[e] = q;
        for (int s = 0; s < NS; s++) begin
            int unsigned v;
            case (scen)
                0: begin v = 100; ty[s] = 5; end
                1: begin v = 40; ty[s] = (s < 4) ? 1 : 2; end
                2: begin v = 40; ty[s] = (s < 3) ? 1 : 2; end
                3: begin
                    v = $urandom_range(0, 100);
                    ty[s] = (v / 20 + 1 > 5) ? 5 : int'(v / 20 + 1);
                end
                default: begin v = 0; ty[s] = $urandom_range(0, NT - 1); end
            endcase
            for (int e = 0; e < MN; e++) tr[s][e] = (scen == 4) ? longint'($urandom) : longint'(v);
        end
        if (scen == 0) begin
            int near [7] = '{3, 11, 20, 29, 38, 47, 60};
            foreach (near[i]) begin
                ty[near[i]] = 2;
                for (int e = 0; e < MN; e++) tr[near[i]][e] = 25;
            end
        end
        if (scen == 4) for (int e = 0; e < MN; e++) qv[e] = $urandom;
    endtask

    // Lanes past the matrix end carry maximal junk that must not count.
    task automatic drive_lanes(input int s, input int b);
        for (int j = 0; j < MAX_ELEMENTS; j++) begin
            int e = b * MAX_ELEMENTS + j;
            if (e < MN) begin
                training_data[W*j +: W] = W'(tr[s][e]);
                input_data[W*j +: W]    = W'(qv[e]);
            end else begin
                training_data[W*j +: W] = '1;
                input_data[W*j +: W]    = '0;
            end
        end
        training_data_type = TYPE_W'(ty[s]);
    endtask

    task automatic send_burst(input int s, input int b, output bit ok);
        logic [3:0] exp_f;
        drive_lanes(s, b);
        read_done = 1'b1;
        tick();
        read_done = 1'b0;
        exp_f = {1'b0, (b < B - 1), (b == B - 1), (b == B - 1 && s == NS - 1)};
        ok = ({inference_done, data_request, done, done_calc} == exp_f);
        tick();
        if ({inference_done, data_request, done, done_calc} != 4'b0000) ok = 1'b0;
    endtask

    task automatic run_set(input string name, input int exp_type);
        int bad;
        int cyc;
        int exp;
        bit ok;
        bad = 0;
        for (int s = 0; s < NS; s++)
            for (int b = 0; b < B; b++) begin
                send_burst(s, b, ok);
                if (!ok) bad++;
            end
        check({name, " handshake bad cycles"}, bad, 0);
        // A read_done during selection must be ignored
        training_data = '1;
        input_data    = '0;
        read_done     = 1'b1;
        tick();
        read_done     = 1'b0;
        cyc = 2;
        check({name, " ignored read_done pulses"}, {data_request, done, done_calc}, 0);
        while (!inference_done && cyc < 3000) begin
            tick();
            cyc++;
        end
        check({name, " inference_done"}, inference_done, 1);
        check({name, " latency in range"}, (cyc >= K * NS && cyc <= K * NS + NT + 3), 1);
        exp = (exp_type < 0) ? model_type() : exp_type;
        check({name, " inferred_type"}, inferred_type, exp);
        repeat (5) tick();
        check({name, " held inference_done"}, inference_done, 1);
        check({name, " held inferred_type"}, inferred_type, exp);
    endtask

    initial begin
        bit ok;
        vecs[0] = '{0, 25, 2};
        vecs[1] = '{1, 10, 1};
        vecs[2] = '{2, 10, 2};
        vecs[3] = '{3, 90, -1};
        vecs[4] = '{3, 25, -1};
        vecs[5] = '{3, 50, -1};
        vecs[6] = '{3, 30, -1};
        vecs[7] = '{3, 10, -1};
        vecs[8] = '{4, 0, -1};

        repeat (3) @(posedge clk);
        #1;
        check("reset data_request", data_request, 0);
        check("reset done", done, 0);
        check("reset done_calc", done_calc, 0);
        check("reset inferred_type", inferred_type, 0);
        check("reset inference_done", inference_done, 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            prep(vecs[v].scen, vecs[v].q);
            run_set($sformatf("set%0d", v), vecs[v].exp);
        end

        // Asynchronous reset in the middle of sample 10
        prep(3, 90);
        for (int s = 0; s < 10; s++)
            for (int b = 0; b < B; b++) send_burst(s, b, ok);
        drive_lanes(10, 0);
        read_done = 1'b1;
        tick();
        read_done = 1'b0;
        check("pre-reset data_request", data_request, 1);
        #2 rst = 1'b1;
        #1;
        check("async reset data_request", data_request, 0);
        check("async reset inference_done", inference_done, 0);
        check("async reset done", done, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        prep(3, 90);
        run_set("after-reset", -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
